multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath (insfetch, regFile, alu, dataMemory). Steps each instruction through
//  IF/ID/EX/MEM/WB so PC, IR, register file and data memory are strobed in separate cycles. Replaces the single-cycle
//  controler strobes, adds a data-memory ready handshake with timeout, a retire counter and a trap state.
// PARAMETERS
//  DM_WAIT_MAX  15  max consecutive MEM cycles with dm_ready=0 before trap; 0 disables timeout
//  CNT_W        32  width of instr_count
// PORTS
//  clk                     in   1      clock, rising edge
//  rst                     in   1      synchronous active-high reset
//  instruction             in   32     current IR contents (valid from ID onward)
//  alu_zero                in   1      ALU zero flag, sampled in EX for beq
//  dm_ready                in   1      data memory completes access this cycle
//  pc_write                out  1      PC register load enable
//  ir_write                out  1      IR load enable
//  npc_sel                 out  1      1 = branch target (PC+4+sext(imm16)<<2)
//  isJump                  out  1      1 = jump target {PC[31:28],imm26,2'b00}
//  select_aluPerformance   out  2      00 add, 01 sub, 10 or, 11 reserved (never driven)
//  select_anotherAluSource out  1      0 = regB, 1 = imm16 (zext for ori, sext for lw/sw)
//  select_regWritten       out  1      1 = rd (R-type), 0 = rt
//  ctrl_regFile_write      out  1      register file write strobe
//  ctrl_dataMem_Write      out  1      data memory write strobe
//  ctrl_dataMem2reg        out  1      1 = writeback from data memory
//  dm_req                  out  1      data memory access request
//  state                   out  3      current state (debug)
//  retire                  out  1      1-cycle pulse, instruction completes
//  instr_count             out  CNT_W  retired instruction count, wraps
//  trap                    out  1      sticky, held until rst
//  trap_cause              out  2      00 none, 01 illegal instr, 10 dm timeout
// BEHAVIOUR
//  States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5. Registers: state, wait_cnt, instr_count, trap_cause.
//  Reset (rst high at clock edge): state<=IF, wait_cnt<=0, instr_count<=0, trap_cause<=00.
//   While rst high all strobes (pc_write, ir_write, regfile/dm writes, dm_req, retire) forced 0.
//  Strobes combinational from state + instruction; pc_write in EX/beq also depends on alu_zero.
//   Unlisted strobes are 0 in every state.
//  IF : ir_write=1, pc_write=1 (npc_sel=0, isJump=0: PC+4) -> ID.
//  ID : decode. Legal set: addu(0/21h), subu(0/23h), ori(0Dh), lw(23h), sw(2Bh), beq(04h), j(02h).
//       illegal -> TRAP, cause 01; else -> EX.
//  EX : R: alu op by funct, src=regB -> WB.  ori: or, src=imm -> WB.
//       lw/sw: add, src=imm -> MEM.
//       beq: sub, src=regB, npc_sel=1, pc_write=alu_zero, retire -> IF.
//       j: isJump=1, pc_write=1, retire -> IF.
//  MEM: dm_req=1; sw also ctrl_dataMem_Write=1. ALU inputs held as in EX.
//       dm_ready=1: lw -> WB; sw retire -> IF; wait_cnt<=0.
//       dm_ready=0: wait_cnt++; when wait_cnt==DM_WAIT_MAX-1 (DM_WAIT_MAX!=0) -> TRAP, cause 10.
//  WB : ctrl_regFile_write=1, retire -> IF.
//       R: select_regWritten=1, ALU op held.  ori: rt, ALU op held.  lw: rt, ctrl_dataMem2reg=1.
//  TRAP: all strobes 0, trap=1; exit only via rst.
//  Cycle counts: beq/j 3, R/ori/sw 4 (+ MEM waits), lw 5 (+ MEM waits).
//  retire is asserted during the final cycle; instr_count += 1 on that edge, wraps at 2**CNT_W.
//  rst mid-MEM aborts the access: dm_req low from the reset cycle, no write issued.
//  dm_ready outside MEM is ignored. trap = (state==TRAP).
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/funct constants, ALU op codes (ALU_ADD/SUB/OR), state encoding, trap cause codes.
//  Sub-module mc_decode (combinational): instruction -> {is_rtype, is_ori, is_lw, is_sw, is_beq, is_j, illegal, alu_op}.
//  Top holds the FSM, wait counter and retire counter.
// TESTING
//  1. addu $3,$1,$2 after reset: states IF,ID,EX,WB. WB has ctrl_regFile_write=1, select_regWritten=1,
//     ALU op 00, retire=1; instr_count=1.
//  2. lw with dm_ready low 2 cycles then high: MEM lasts 3 cycles with dm_req=1, then WB with
//     ctrl_dataMem2reg=1; 7 cycles total.
//  3. beq taken (alu_zero=1) vs not-taken: pc_write=1 vs 0 in EX with npc_sel=1; both retire; 3 cycles.
//  4. sw with dm_ready never asserted, DM_WAIT_MAX=15: 15 MEM cycles with write asserted, then TRAP,
//     trap_cause=10, strobes 0.
//  5. Opcode 3Fh: TRAP after ID, trap_cause=01. Following rst: state=IF, instr_count=0, trap=0.
//  6. rst during MEM of a sw: next cycle state=IF, dm_req=0, ctrl_dataMem_Write=0, wait_cnt=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice.
// Contents: opcode/funct constants, ALU op codes, FSM state encoding,
// trap cause codes, the decoded-instruction payload and field helpers.
package mips_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  // Primary opcodes of the supported subset
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;

  // ALU operation select; 2'b11 is reserved and never produced
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10
  } aluOp_t;

  // Sequencer states; encoding is visible on the debug state port
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd5
  } ctrlState_t;

  typedef enum logic [1:0] {
    TRAP_NONE       = 2'b00,
    TRAP_ILLEGAL    = 2'b01,
    TRAP_DM_TIMEOUT = 2'b10
  } trapCause_t;

  // Decoded instruction class, one-hot over the legal set plus illegal
  typedef struct packed {
    logic   isRtype;
    logic   isOri;
    logic   isLw;
    logic   isSw;
    logic   isBeq;
    logic   isJ;
    logic   illegal;
    aluOp_t aluOp;
  } decInfo_t;

  function automatic logic [OP_W-1:0] opcodeOf(input logic [INSTR_W-1:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [OP_W-1:0] functOf(input logic [INSTR_W-1:0] ins);
    return ins[5:0];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for the multi-cycle sequencer.
// Ports:
//   instruction  in   32  current IR contents
//   dec          out  decInfo_t  instruction class flags, illegal flag, ALU op
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instruction,
  output decInfo_t           dec
);

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            unusedBits;

  assign opcode = opcodeOf(instruction);
  assign funct  = functOf(instruction);

  // Register numbers and immediates are datapath business, not control
  assign unusedBits = ^instruction[25:6];

  // Classify opcode/funct; anything outside the legal set is flagged illegal
  always_comb begin
    dec       = '0;
    dec.aluOp = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          dec.isRtype = 1'b1;
          dec.aluOp   = ALU_ADD;
        end else if (funct == FN_SUBU) begin
          dec.isRtype = 1'b1;
          dec.aluOp   = ALU_SUB;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ORI: begin
        dec.isOri = 1'b1;
        dec.aluOp = ALU_OR;
      end
      OP_LW:   dec.isLw = 1'b1;
      OP_SW:   dec.isSw = 1'b1;
      OP_BEQ: begin
        dec.isBeq = 1'b1;
        dec.aluOp = ALU_SUB;
      end
      OP_J:    dec.isJ = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: steps each instruction through
// IF/ID/EX/MEM/WB, handshakes data memory with a timeout, counts retired
// instructions and parks in a sticky trap state on illegal opcodes/timeouts.
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   instruction              IR contents, valid from ID onward
//   alu_zero                 ALU zero flag, used by beq in EX
//   dm_ready                 data memory completes its access this cycle
//   pc_write, ir_write       PC / IR load enables
//   npc_sel, isJump          next-PC select: branch target / jump target
//   select_aluPerformance    ALU op (00 add, 01 sub, 10 or)
//   select_anotherAluSource  ALU B source (0 regB, 1 imm16)
//   select_regWritten        destination register (1 rd, 0 rt)
//   ctrl_regFile_write       register file write strobe
//   ctrl_dataMem_Write       data memory write strobe
//   ctrl_dataMem2reg         writeback from data memory
//   dm_req                   data memory access request
//   state                    current state (debug)
//   retire                   pulse in the final cycle of an instruction
//   instr_count              retired instruction count, wraps
//   trap, trap_cause         sticky trap flag and its cause
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DM_WAIT_MAX = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               alu_zero,
  input  logic               dm_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               npc_sel,
  output logic               isJump,
  output logic [1:0]         select_aluPerformance,
  output logic               select_anotherAluSource,
  output logic               select_regWritten,
  output logic               ctrl_regFile_write,
  output logic               ctrl_dataMem_Write,
  output logic               ctrl_dataMem2reg,
  output logic               dm_req,
  output logic [2:0]         state,
  output logic               retire,
  output logic [CNT_W-1:0]   instr_count,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  // Wait counter only needs to reach DM_WAIT_MAX-1
  localparam int unsigned WAIT_W = (DM_WAIT_MAX < 2) ? 1 : $clog2(DM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((DM_WAIT_MAX == 0) ? 32'd0 : DM_WAIT_MAX - 32'd1);

  ctrlState_t        curState;
  trapCause_t        trapCause;
  logic [WAIT_W-1:0] waitCnt;
  decInfo_t          dec;

  mc_decode uDecode (
    .instruction (instruction),
    .dec         (dec)
  );

  assign state      = curState;
  assign trap       = (curState == ST_TRAP);
  assign trap_cause = trapCause;

  // State sequencing, MEM wait counter and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      curState    <= ST_IF;
      waitCnt     <= '0;
      instr_count <= '0;
      trapCause   <= TRAP_NONE;
    end else begin
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      case (curState)
        ST_IF: curState <= ST_ID;
        ST_ID: begin
          if (dec.illegal) begin
            curState  <= ST_TRAP;
            trapCause <= TRAP_ILLEGAL;
          end else begin
            curState <= ST_EX;
          end
        end
        ST_EX: begin
          waitCnt <= '0;
          if (dec.isLw || dec.isSw) begin
            curState <= ST_MEM;
          end else if (dec.isRtype || dec.isOri) begin
            curState <= ST_WB;
          end else begin
            curState <= ST_IF;
          end
        end
        ST_MEM: begin
          if (dm_ready) begin
            waitCnt  <= '0;
            curState <= dec.isLw ? ST_WB : ST_IF;
          end else if ((DM_WAIT_MAX != 0) && (waitCnt == WAIT_LAST)) begin
            curState  <= ST_TRAP;
            trapCause <= TRAP_DM_TIMEOUT;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        ST_WB:   curState <= ST_IF;
        ST_TRAP: curState <= ST_TRAP;
        default: curState <= ST_IF;
      endcase
    end
  end

  // Per-state strobes and datapath selects; strobes are killed while in reset
  always_comb begin
    pc_write                = 1'b0;
    ir_write                = 1'b0;
    npc_sel                 = 1'b0;
    isJump                  = 1'b0;
    select_aluPerformance   = ALU_ADD;
    select_anotherAluSource = 1'b0;
    select_regWritten       = 1'b0;
    ctrl_regFile_write      = 1'b0;
    ctrl_dataMem_Write      = 1'b0;
    ctrl_dataMem2reg        = 1'b0;
    dm_req                  = 1'b0;
    retire                  = 1'b0;

    case (curState)
      ST_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      ST_EX: begin
        if (dec.isRtype) begin
          select_aluPerformance = dec.aluOp;
        end else if (dec.isOri) begin
          select_aluPerformance   = ALU_OR;
          select_anotherAluSource = 1'b1;
        end else if (dec.isLw || dec.isSw) begin
          select_aluPerformance   = ALU_ADD;
          select_anotherAluSource = 1'b1;
        end else if (dec.isBeq) begin
          select_aluPerformance = ALU_SUB;
          npc_sel               = 1'b1;
          pc_write              = alu_zero;
          retire                = 1'b1;
        end else if (dec.isJ) begin
          isJump   = 1'b1;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_MEM: begin
        // Address computation stays on the ALU for the whole access
        dm_req                  = 1'b1;
        ctrl_dataMem_Write      = dec.isSw;
        select_aluPerformance   = ALU_ADD;
        select_anotherAluSource = 1'b1;
        retire                  = dec.isSw && dm_ready;
      end
      ST_WB: begin
        ctrl_regFile_write = 1'b1;
        retire             = 1'b1;
        if (dec.isRtype) begin
          select_regWritten     = 1'b1;
          select_aluPerformance = dec.aluOp;
        end else if (dec.isOri) begin
          select_aluPerformance   = ALU_OR;
          select_anotherAluSource = 1'b1;
        end else if (dec.isLw) begin
          ctrl_dataMem2reg = 1'b1;
        end
      end
      default: ;
    endcase

    if (rst) begin
      pc_write           = 1'b0;
      ir_write           = 1'b0;
      ctrl_regFile_write = 1'b0;
      ctrl_dataMem_Write = 1'b0;
      dm_req             = 1'b0;
      retire             = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction
// streams checked against an instruction-level model (cycle count, state
// sequence and per-instruction strobe totals).
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        dm_ready;
  logic        pc_write, ir_write, npc_sel, isJump;
  logic [1:0]  select_aluPerformance;
  logic        select_anotherAluSource, select_regWritten;
  logic        ctrl_regFile_write, ctrl_dataMem_Write, ctrl_dataMem2reg;
  logic        dm_req;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instr_count;
  logic        trap;
  logic [1:0]  trap_cause;

  int total = 0;
  int bad   = 0;
  int expCount = 0;

  multicycle_ctrl #(.DM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .instruction             (instruction),
    .alu_zero                (alu_zero),
    .dm_ready                (dm_ready),
    .pc_write                (pc_write),
    .ir_write                (ir_write),
    .npc_sel                 (npc_sel),
    .isJump                  (isJump),
    .select_aluPerformance   (select_aluPerformance),
    .select_anotherAluSource (select_anotherAluSource),
    .select_regWritten       (select_regWritten),
    .ctrl_regFile_write      (ctrl_regFile_write),
    .ctrl_dataMem_Write      (ctrl_dataMem_Write),
    .ctrl_dataMem2reg        (ctrl_dataMem2reg),
    .dm_req                  (dm_req),
    .state                   (state),
    .retire                  (retire),
    .instr_count             (instr_count),
    .trap                    (trap),
    .trap_cause              (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Instruction classes: 0 addu 1 subu 2 ori 3 lw 4 sw 5 beq 6 j
  function automatic logic [31:0] mkInstr(input int cls);
    logic [25:0] r;
    r = 26'($urandom);
    case (cls)
      0:       return {6'h00, r[25:6], 6'h21};
      1:       return {6'h00, r[25:6], 6'h23};
      2:       return {6'h0D, r};
      3:       return {6'h23, r};
      4:       return {6'h2B, r};
      5:       return {6'h04, r};
      default: return {6'h02, r};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; strobes must be dead while rst is high
  task automatic doReset();
    rst = 1'b1;
    dm_ready = 1'b0;
    nextCyc();
    #1;
    chk("rstPcWrite", 32'(pc_write), 0);
    chk("rstIrWrite", 32'(ir_write), 0);
    chk("rstState", 32'(state), 0);
    chk("rstCount", instr_count, 0);
    chk("rstTrap", 32'(trap), 0);
    chk("rstCause", 32'(trap_cause), 0);
    nextCyc();
    rst = 1'b0;
    expCount = 0;
  endtask

  // Run one legal instruction from its IF cycle; d = MEM cycles with dm_ready low
  task automatic runInstr(input int cls, input int d, input logic zero);
    int  expSt[$];
    int  n, retAt;
    int  cPc, cIr, cRf, cDmw, cDmr, cD2r, cNpc, cJ, cRet;
    int  wbSel, wbAlu, wbSrc, brAlu;
    bit  isMem, hasWb;
    isMem = (cls == 3) || (cls == 4);
    hasWb = (cls <= 3);
    expSt = '{0, 1, 2};
    if (isMem) repeat (d + 1) expSt.push_back(3);
    if (hasWb) expSt.push_back(4);
    n = expSt.size();
    cPc = 0; cIr = 0; cRf = 0; cDmw = 0; cDmr = 0; cD2r = 0; cNpc = 0; cJ = 0; cRet = 0;
    retAt = -1; wbSel = -1; wbAlu = -1; wbSrc = -1; brAlu = -1;
    instruction = mkInstr(cls);
    alu_zero = zero;
    for (int c = 0; c < n; c++) begin
      if (isMem && c >= 3 && c <= 3 + d) dm_ready = (c == 3 + d);
      else dm_ready = 1'($urandom);
      #1;
      chk($sformatf("state[c%0d]", c), 32'(state), 32'(expSt[c]));
      cPc += int'(pc_write);
      cIr += int'(ir_write);
      cDmw += int'(ctrl_dataMem_Write);
      cDmr += int'(dm_req);
      cD2r += int'(ctrl_dataMem2reg);
      cNpc += int'(npc_sel);
      cJ += int'(isJump);
      if (retire) begin cRet++; retAt = c; end
      if (ctrl_regFile_write) begin
        cRf++;
        wbSel = int'(select_regWritten);
        wbAlu = int'(select_aluPerformance);
        wbSrc = int'(select_anotherAluSource);
      end
      if (npc_sel) brAlu = int'(select_aluPerformance);
      nextCyc();
    end
    expCount++;
    chk("irWrites", 32'(cIr), 1);
    chk("pcWrites", 32'(cPc), 32'(1 + int'(cls == 6) + int'(cls == 5 && zero)));
    chk("rfWrites", 32'(cRf), 32'(int'(hasWb)));
    chk("dmReqs", 32'(cDmr), isMem ? 32'(d + 1) : 0);
    chk("dmWrites", 32'(cDmw), (cls == 4) ? 32'(d + 1) : 0);
    chk("dm2reg", 32'(cD2r), 32'(int'(cls == 3)));
    chk("npcSel", 32'(cNpc), 32'(int'(cls == 5)));
    chk("isJump", 32'(cJ), 32'(int'(cls == 6)));
    chk("retires", 32'(cRet), 1);
    chk("retireAt", 32'(retAt), 32'(n - 1));
    chk("instrCount", instr_count, 32'(expCount));
    if (cls <= 1) begin
      chk("wbRd", 32'(wbSel), 1);
      chk("wbAluR", 32'(wbAlu), 32'(cls));
      chk("wbSrcR", 32'(wbSrc), 0);
    end
    if (cls == 2) begin
      chk("wbRt", 32'(wbSel), 0);
      chk("wbAluOri", 32'(wbAlu), 2);
      chk("wbSrcOri", 32'(wbSrc), 1);
    end
    if (cls == 3) chk("wbRtLw", 32'(wbSel), 0);
    if (cls == 5) chk("brAluSub", 32'(brAlu), 1);
    chk("backToIF", 32'(state), 0);
  endtask

  initial begin
    rst = 1'b1;
    instruction = 32'h0;
    alu_zero = 1'b0;
    dm_ready = 1'b0;
    doReset();

    // addu $3,$1,$2 right after reset
    runInstr(0, 0, 1'b0);
    // lw with two stalled MEM cycles
    runInstr(3, 2, 1'b0);
    // beq taken then not taken
    runInstr(5, 0, 1'b1);
    runInstr(5, 0, 1'b0);

    // Random legal stream with random memory latency
    for (int i = 0; i < 40; i++) begin
      runInstr(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'($urandom));
    end

    // sw with dm_ready never asserted: timeout trap after 15 MEM cycles
    instruction = mkInstr(4);
    dm_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("swToState", 32'(state), 32'(c));
      nextCyc();
    end
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("toMem[%0d]", k), 32'(state), 3);
      chk($sformatf("toWr[%0d]", k), 32'(ctrl_dataMem_Write & dm_req), 1);
      nextCyc();
    end
    #1;
    chk("toTrapState", 32'(state), 5);
    chk("toTrap", 32'(trap), 1);
    chk("toCause", 32'(trap_cause), 2);
    chk("toStrobes", 32'({pc_write, ir_write, ctrl_regFile_write, ctrl_dataMem_Write, dm_req, retire}), 0);
    dm_ready = 1'b1;
    nextCyc();
    #1;
    chk("toSticky", 32'({trap, trap_cause}), 32'h6);
    chk("toCountHeld", instr_count, 32'(expCount));

    // Illegal opcode 3Fh traps after ID; reset clears everything
    doReset();
    instruction = {6'h3F, 26'($urandom)};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("illState", 32'(state), 32'(c));
      nextCyc();
    end
    #1;
    chk("illTrapState", 32'(state), 5);
    chk("illCause", 32'(trap_cause), 1);
    chk("illStrobes", 32'({pc_write, ir_write, retire, dm_req}), 0);
    doReset();
    #1;
    chk("postIllState", 32'(state), 0);
    chk("postIllTrap", 32'(trap), 0);
    chk("postIllCount", instr_count, 0);
    nextCyc();

    // Reset in the middle of a sw access aborts it
    doReset();
    instruction = mkInstr(4);
    dm_ready = 1'b0;
    for (int c = 0; c < 3; c++) nextCyc();
    #1;
    chk("abMemReq", 32'(dm_req), 1);
    nextCyc();
    rst = 1'b1;
    #1;
    chk("abRstReq", 32'(dm_req), 0);
    chk("abRstWr", 32'(ctrl_dataMem_Write), 0);
    nextCyc();
    rst = 1'b0;
    #1;
    chk("abState", 32'(state), 0);
    chk("abReq", 32'(dm_req), 0);
    chk("abWr", 32'(ctrl_dataMem_Write), 0);
    chk("abWaitCnt", 32'(dut.waitCnt), 0);
    chk("abCount", instr_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
